// File: rtl/slc3_pkg.sv
// ============================================================================
// Module  : slc3_pkg
// Brief   : Shared types and constants for the SLC-3 memory responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package slc3_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } mem_state_t;

    localparam word_t IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/slc3_ram.sv
// ============================================================================
// Module  : slc3_ram
// Brief   : Single-port synchronous RAM, 2**ADDR_W x 16, registered read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module slc3_ram
    import slc3_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  word_t             i_wdata,
    output word_t             o_rdata
);

    word_t r_mem [0:(2**ADDR_W)-1];
    word_t r_rdata;

    // Read data only moves on a read access, so it holds across writes.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/slc3_mem_responder.sv
// ============================================================================
// Module  : slc3_mem_responder
// Brief   : SLC-3 bus responder: wait-stated RAM / switch / hex-display access.
// Revision: 1.0
// ============================================================================
`default_nettype none

module slc3_mem_responder
    import slc3_pkg::*;
#(
    parameter int    ADDR_W      = 10,
    parameter int    WAIT_STATES = 2,
    parameter word_t IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WE,
    input  word_t       Addr,
    input  word_t       Data_In,
    output word_t       Data_Out,
    output logic        Ack,
    output logic        Err,
    input  logic [9:0]  SW,
    output word_t       Hex_Data
);

    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_STATES);

    mem_state_t  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    word_t       r_addr;
    word_t       r_wdata;
    logic        r_err;
    logic        r_rsel_ram;
    word_t       r_rdata;
    word_t       r_hex;

    logic        w_go_ack;
    logic        w_cur_we;
    word_t       w_cur_addr;
    word_t       w_cur_data;
    logic        w_hit_io;
    logic        w_hit_ram;
    logic        w_ram_en;
    word_t       w_ram_q;

    // With zero wait states the edge entering ACK is the request-sample edge,
    // so the live bus is used instead of the (not yet loaded) latches.
    assign w_go_ack   = ((r_state == IDLE) && Req && (WAIT_STATES == 0)) ||
                        ((r_state == WAIT) && (r_cnt == 4'd1));
    assign w_cur_we   = (r_state == IDLE) ? WE      : r_we;
    assign w_cur_addr = (r_state == IDLE) ? Addr    : r_addr;
    assign w_cur_data = (r_state == IDLE) ? Data_In : r_wdata;

    assign w_hit_io  = (w_cur_addr == IO_ADDR);
    assign w_hit_ram = !w_hit_io && (32'(w_cur_addr) < (32'd1 << ADDR_W));
    assign w_ram_en  = w_go_ack && w_hit_ram;

    slc3_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (Clk),
        .i_en    (w_ram_en),
        .i_we    (w_cur_we),
        .i_addr  (w_cur_addr[ADDR_W-1:0]),
        .i_wdata (w_cur_data),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_rsel_ram <= 1'b0;
            r_rdata    <= '0;
            r_hex      <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Req) begin
                        r_we    <= WE;
                        r_addr  <= Addr;
                        r_wdata <= Data_In;
                        r_cnt   <= c_WAIT_LOAD;
                        r_state <= (WAIT_STATES == 0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ACK;
                    end
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (w_go_ack) begin
                r_err <= !w_hit_io && !w_hit_ram;
                if (w_cur_we) begin
                    if (w_hit_io) begin
                        r_hex <= w_cur_data;
                    end
                end else begin
                    r_rsel_ram <= w_hit_ram;
                    r_rdata    <= w_hit_io ? {6'b0, SW} : 16'h0000;
                end
            end
        end
    end

    assign Data_Out = r_rsel_ram ? w_ram_q : r_rdata;
    assign Ack      = (r_state == ACK);
    assign Err      = r_err;
    assign Hex_Data = r_hex;

endmodule

`default_nettype wire

// File: tb/tb_slc3_mem_responder.sv
// ============================================================================
// Module  : tb_slc3_mem_responder
// Brief   : Directed self-checking bench for slc3_mem_responder (2 wait states).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_slc3_mem_responder;

    logic        clk;
    logic        Reset;
    logic        Req;
    logic        WE;
    logic [15:0] Addr;
    logic [15:0] Data_In;
    logic [15:0] Data_Out;
    logic        Ack;
    logic        Err;
    logic [9:0]  SW;
    logic [15:0] Hex_Data;

    int n_cmp  = 0;
    int n_fail = 0;

    slc3_mem_responder #(
        .ADDR_W      (10),
        .WAIT_STATES (2),
        .IO_ADDR     (16'hFFFF)
    ) dut (
        .Clk      (clk),
        .Reset    (Reset),
        .Req      (Req),
        .WE       (WE),
        .Addr     (Addr),
        .Data_In  (Data_In),
        .Data_Out (Data_Out),
        .Ack      (Ack),
        .Err      (Err),
        .SW       (SW),
        .Hex_Data (Hex_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and returns the number of edges until Ack (-1 on timeout)
    // plus the outputs seen in the Ack cycle. Bus inputs are scrambled after the
    // sample edge so only the latched copies can produce the right answer.
    task automatic do_txn(input logic we, input logic [15:0] addr, input logic [15:0] data,
                          output int lat, output logic [15:0] dout, output logic err,
                          output logic [15:0] hex);
        lat  = -1;
        dout = 16'h0;
        err  = 1'b0;
        hex  = 16'h0;
        Req     = 1'b1;
        WE      = we;
        Addr    = addr;
        Data_In = data;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                Req     = 1'b0;
                WE      = ~we;
                Addr    = 16'h0BAD;
                Data_In = 16'h5555;
            end
            if (Ack) begin
                lat  = k;
                dout = Data_Out;
                err  = Err;
                hex  = Hex_Data;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (Ack !== 1'b0)          begin n_fail++; $display("FAIL reset_ack: got %b want 0", Ack); end
        n_cmp++; if (Err !== 1'b0)          begin n_fail++; $display("FAIL reset_err: got %b want 0", Err); end
        n_cmp++; if (Data_Out !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h want 0000", Data_Out); end
        n_cmp++; if (Hex_Data !== 16'h0000) begin n_fail++; $display("FAIL reset_hex: got %h want 0000", Hex_Data); end
        Reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ram_rw();
        int lat; logic [15:0] d; logic e; logic [15:0] h;
        do_txn(1'b1, 16'h0012, 16'hBEEF, lat, d, e, h);
        n_cmp++; if (lat !== 3)      begin n_fail++; $display("FAIL wr_latency: got %0d want 3", lat); end
        n_cmp++; if (e !== 1'b0)     begin n_fail++; $display("FAIL wr_err: got %b want 0", e); end
        do_txn(1'b0, 16'h0012, 16'h0000, lat, d, e, h);
        n_cmp++; if (lat !== 3)      begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lat); end
        n_cmp++; if (d !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h want beef", d); end
        n_cmp++; if (e !== 1'b0)     begin n_fail++; $display("FAIL rd_err: got %b want 0", e); end
        do_txn(1'b1, 16'h03FF, 16'h5A5A, lat, d, e, h);
        do_txn(1'b1, 16'h0000, 16'h0F0F, lat, d, e, h);
        do_txn(1'b1, 16'h0005, 16'h1111, lat, d, e, h);
        do_txn(1'b0, 16'h0005, 16'h0000, lat, d, e, h);
        n_cmp++; if (d !== 16'h1111) begin n_fail++; $display("FAIL rd_0005: got %h want 1111", d); end
    endtask

    task automatic test_io_read();
        int lat; logic [15:0] d; logic e; logic [15:0] h;
        SW = 10'h01A;
        do_txn(1'b0, 16'hFFFF, 16'h0000, lat, d, e, h);
        n_cmp++; if (d !== 16'h001A) begin n_fail++; $display("FAIL sw_1a: got %h want 001a", d); end
        n_cmp++; if (e !== 1'b0)     begin n_fail++; $display("FAIL sw_err: got %b want 0", e); end
        SW = 10'h033;
        do_txn(1'b0, 16'hFFFF, 16'h0000, lat, d, e, h);
        n_cmp++; if (d !== 16'h0033) begin n_fail++; $display("FAIL sw_33: got %h want 0033", d); end
    endtask

    task automatic test_io_write();
        int lat; logic [15:0] d; logic e; logic [15:0] h;
        do_txn(1'b1, 16'hFFFF, 16'h1234, lat, d, e, h);
        n_cmp++; if (h !== 16'h1234) begin n_fail++; $display("FAIL hex_wr: got %h want 1234", h); end
        n_cmp++; if (d !== 16'h0033) begin n_fail++; $display("FAIL hex_wr_dout_held: got %h want 0033", d); end
        n_cmp++; if (lat !== 3)      begin n_fail++; $display("FAIL hex_wr_latency: got %0d want 3", lat); end
        do_txn(1'b0, 16'h03FF, 16'h0000, lat, d, e, h);
        n_cmp++; if (d !== 16'h5A5A) begin n_fail++; $display("FAIL ram_3ff_kept: got %h want 5a5a", d); end
    endtask

    task automatic test_unmapped();
        int lat; logic [15:0] d; logic e; logic [15:0] h;
        do_txn(1'b0, 16'h4000, 16'h0000, lat, d, e, h);
        n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL unm_rd_data: got %h want 0000", d); end
        n_cmp++; if (e !== 1'b1)     begin n_fail++; $display("FAIL unm_rd_err: got %b want 1", e); end
        n_cmp++; if (Err !== 1'b0)   begin n_fail++; $display("FAIL unm_err_pulse: got %b want 0", Err); end
        do_txn(1'b1, 16'h4000, 16'hDEAD, lat, d, e, h);
        n_cmp++; if (e !== 1'b1)     begin n_fail++; $display("FAIL unm_wr_err: got %b want 1", e); end
        n_cmp++; if (h !== 16'h1234) begin n_fail++; $display("FAIL unm_wr_hex: got %h want 1234", h); end
        n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL unm_wr_dout: got %h want 0000", d); end
        do_txn(1'b0, 16'h0000, 16'h0000, lat, d, e, h);
        n_cmp++; if (d !== 16'h0F0F) begin n_fail++; $display("FAIL unm_wr_ram0: got %h want 0f0f", d); end
    endtask

    task automatic test_back_to_back();
        int          n_ack;
        int          ack_k [3];
        logic [15:0] ack_d [3];
        logic [15:0] exp_d [3];
        int          exp_k [3];
        exp_d = '{16'hBEEF, 16'h5A5A, 16'h0F0F};
        exp_k = '{3, 7, 11};
        ack_k = '{-1, -1, -1};
        ack_d = '{16'h0, 16'h0, 16'h0};
        n_ack = 0;
        Req  = 1'b1;
        WE   = 1'b0;
        Addr = 16'h0012;
        for (int k = 1; k <= 24 && n_ack < 3; k++) begin
            @(posedge clk); #1;
            if (k == 1) Addr = 16'h03FF;
            if (k == 5) Addr = 16'h0000;
            if (k == 9) Addr = 16'h0012;
            if (Ack) begin
                ack_k[n_ack] = k;
                ack_d[n_ack] = Data_Out;
                n_ack++;
                if (n_ack == 3) Req = 1'b0;
            end
        end
        n_cmp++; if (n_ack !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", n_ack); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ack_k[i] !== exp_k[i]) begin n_fail++; $display("FAIL b2b_cycle%0d: got %0d want %0d", i, ack_k[i], exp_k[i]); end
            n_cmp++;
            if (ack_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, ack_d[i], exp_d[i]); end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int   lat; logic [15:0] d; logic e; logic [15:0] h;
        logic seen_ack;
        seen_ack = 1'b0;
        Req     = 1'b1;
        WE      = 1'b1;
        Addr    = 16'h0005;
        Data_In = 16'hAAAA;
        @(posedge clk); #1;
        Req   = 1'b0;
        Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (Ack) seen_ack = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen_ack !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_ack: got %b want 0", seen_ack); end
        n_cmp++; if (Hex_Data !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_hex: got %h want 0000", Hex_Data); end
        n_cmp++; if (Data_Out !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_dout: got %h want 0000", Data_Out); end
        do_txn(1'b0, 16'h0005, 16'h0000, lat, d, e, h);
        n_cmp++; if (d !== 16'h1111) begin n_fail++; $display("FAIL rst_mid_ram: got %h want 1111", d); end
        n_cmp++; if (lat !== 3)      begin n_fail++; $display("FAIL rst_mid_latency: got %0d want 3", lat); end
    endtask

    initial begin
        Reset   = 1'b1;
        Req     = 1'b0;
        WE      = 1'b0;
        Addr    = 16'h0000;
        Data_In = 16'h0000;
        SW      = 10'h000;
        test_reset();
        test_ram_rw();
        test_io_read();
        test_io_write();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
